// File: rtl/seq_arith_unit.sv
// Sequential arithmetic stage: add/sub in one cycle, shift-add multiply and
// restoring divide over WIDTH iterations; result presented with a one-cycle Done.
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   data_in_i,
    input  logic               load_a_i,
    input  logic               load_b_i,
    input  logic [1:0]         op_i,
    input  logic               start_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               neg_o,
    output logic               err_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 neg_q, neg_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [2*WIDTH-1:0]   add_res;
    logic [2*WIDTH-1:0]   sub_res;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   iter_next;

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};
    assign add_res  = {{(WIDTH-1){1'b0}}, add_sum};
    assign sub_res  = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};

    // work_q is {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, dsr_q} : '0);
    assign mul_next  = {mul_sum, work_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the top bit is clear whenever the trial fails.
    assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, dsr_q});
    assign div_diff  = div_shift[WIDTH-1:0] - dsr_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};

    assign iter_next = (op_q == OP_DIV) ? div_next : mul_next;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        dsr_d    = dsr_q;
        work_d   = work_q;
        result_d = result_q;
        neg_d    = neg_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (load_a_i) a_d = data_in_i;
                if (load_b_i) b_d = data_in_i;
                if (start_i) begin
                    neg_d = 1'b0;
                    err_d = 1'b0;
                    op_d  = op_i;
                    case (op_i)
                        OP_ADD: begin
                            result_d = add_res;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            result_d = sub_res;
                            neg_d    = (a_q < b_q);
                            state_d  = S_DONE;
                        end
                        OP_MUL: begin
                            work_d  = {{WIDTH{1'b0}}, a_q};
                            dsr_d   = b_q;
                            count_d = CW'(WIDTH);
                            state_d = S_RUN;
                        end
                        default: begin
                            if (b_q == '0) begin
                                result_d = '1;
                                err_d    = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                work_d  = {{WIDTH{1'b0}}, a_q};
                                dsr_d   = b_q;
                                count_d = CW'(WIDTH);
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
            S_RUN: begin
                work_d = iter_next;
                if (count_q == CW'(1)) begin
                    result_d = iter_next;
                    count_d  = '0;
                    state_d  = S_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            dsr_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            dsr_q    <= dsr_d;
            work_q   <= work_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign neg_o    = neg_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit: vector table for each op plus
// hand-written sequences for load/start interactions and mid-operation reset.
module tb_seq_arith_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  data_in_i;
    logic        load_a_i;
    logic        load_b_i;
    logic [1:0]  op_i;
    logic        start_i;
    logic [15:0] result_o;
    logic        busy_o;
    logic        done_o;
    logic        neg_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    seq_arith_unit #(.WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_in_i (data_in_i),
        .load_a_i  (load_a_i),
        .load_b_i  (load_b_i),
        .op_i      (op_i),
        .start_i   (start_i),
        .result_o  (result_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .neg_o     (neg_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] res;
        logic        neg;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        data_in_i = a; load_a_i = 1'b1;
        tick();
        load_a_i = 1'b0; data_in_i = b; load_b_i = 1'b1;
        tick();
        load_b_i = 1'b0;
    endtask

    // Pulses Start, waits (bounded) for Done, then checks latency, busy length,
    // outputs, the one-cycle Done width and that Result/Err hold afterwards.
    // inject>0 drives a Start+LoadA intrusion before edge number inject.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [15:0] er,
                          input logic en, input logic ee, input int elat, input int inject);
        int k;
        int busy_n;
        bit seen;
        op_i = op; start_i = 1'b1;
        tick();
        start_i = 1'b0; load_a_i = 1'b0; load_b_i = 1'b0;
        k = 1; busy_n = 0; seen = 1'b0;
        while (k <= 20 && !seen) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) busy_n++;
                if (k == inject) begin
                    start_i = 1'b1; op_i = 2'b00; load_a_i = 1'b1; data_in_i = 8'd1;
                end
                tick();
                start_i = 1'b0; load_a_i = 1'b0;
                k++;
            end
        end
        chk({nm, "_latency"}, seen ? k : 0, elat);
        chk({nm, "_busy"}, busy_n, elat - 1);
        chk({nm, "_result"}, result_o, er);
        chk({nm, "_neg"}, neg_o, en);
        chk({nm, "_err"}, err_o, ee);
        tick();
        chk({nm, "_done_width"}, done_o, 1'b0);
        chk({nm, "_hold"}, {err_o, result_o}, {ee, er});
    endtask

    initial begin
        int dn;
        vecs[0]  = '{8'd200, 8'd100, 2'b00, 16'h012C, 1'b0, 1'b0, 1};
        vecs[1]  = '{8'd5,   8'd9,   2'b01, 16'hFFFC, 1'b1, 1'b0, 1};
        vecs[2]  = '{8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 1'b0, 9};
        vecs[3]  = '{8'd200, 8'd7,   2'b11, 16'h041C, 1'b0, 1'b0, 9};
        vecs[4]  = '{8'd9,   8'd0,   2'b11, 16'hFFFF, 1'b0, 1'b1, 1};
        vecs[5]  = '{8'd13,  8'd11,  2'b10, 16'h008F, 1'b0, 1'b0, 9};
        vecs[6]  = '{8'd9,   8'd5,   2'b01, 16'h0004, 1'b0, 1'b0, 1};
        vecs[7]  = '{8'd255, 8'd255, 2'b00, 16'h01FE, 1'b0, 1'b0, 1};
        vecs[8]  = '{8'd7,   8'd200, 2'b11, 16'h0700, 1'b0, 1'b0, 9};
        vecs[9]  = '{8'd0,   8'd37,  2'b10, 16'h0000, 1'b0, 1'b0, 9};
        vecs[10] = '{8'd255, 8'd1,   2'b11, 16'h00FF, 1'b0, 1'b0, 9};
        vecs[11] = '{8'd0,   8'd255, 2'b01, 16'hFF01, 1'b1, 1'b0, 1};

        rst_i = 1'b1; data_in_i = '0; load_a_i = 1'b0; load_b_i = 1'b0;
        op_i = 2'b00; start_i = 1'b0;
        tick(); tick();
        chk("rst_outputs", {result_o, busy_o, done_o, neg_o, err_o}, '0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            load(vecs[i].a, vecs[i].b);
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].res,
                   vecs[i].neg, vecs[i].err, vecs[i].lat, 0);
        end

        // Both loads on one edge capture the same value.
        data_in_i = 8'd6; load_a_i = 1'b1; load_b_i = 1'b1;
        tick();
        load_a_i = 1'b0; load_b_i = 1'b0;
        run_op("both_load", 2'b10, 16'd36, 1'b0, 1'b0, 9, 0);

        // Start with a load on the same edge uses the old A; the new A is kept.
        load(8'd10, 8'd3);
        data_in_i = 8'd50; load_a_i = 1'b1;
        run_op("start_load", 2'b00, 16'd13, 1'b0, 1'b0, 1, 0);
        run_op("start_load_after", 2'b00, 16'd53, 1'b0, 1'b0, 1, 0);

        // Start and LoadA during a running multiply are ignored.
        load(8'd12, 8'd10);
        run_op("mult_intrude", 2'b10, 16'd120, 1'b0, 1'b0, 9, 3);
        run_op("mult_intrude_a", 2'b00, 16'd22, 1'b0, 1'b0, 1, 0);

        // Reset during a divide aborts with no Done.
        load(8'd200, 8'd7);
        op_i = 2'b11; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        chk("div_busy_before_rst", busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_outputs", {result_o, busy_o, done_o, neg_o, err_o}, '0);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_o) dn++;
            tick();
        end
        chk("abort_no_done", dn, 0);
        run_op("post_rst_zero", 2'b00, 16'd0, 1'b0, 1'b0, 1, 0);
        load(8'd3, 8'd4);
        run_op("post_rst_add", 2'b00, 16'd7, 1'b0, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
